// File: rtl/snes_mem_arbiter_pkg.sv
// Shared definitions for the SNES/GSU memory arbiter.
//   arb_state_t          : arbiter FSM states (idle, SNES access, GSU access)
//   SYNC_STAGES_DEFAULT  : default depth of the SNES strobe synchronizers
package snes_mem_arbiter_pkg;

  localparam int unsigned SYNC_STAGES_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SNES = 2'd1,
    ST_GSU  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/snes_mem_arbiter_sync.sv
// snes_strobe_sync: synchronizer for one raw active-low SNES bus strobe.
//   clk, rst  : system clock, synchronous active-high reset
//   strobe_n  : raw asynchronous strobe (/RD or /WR)
//   fell      : 1-cycle pulse, strobe asserted (high -> low)
//   rose      : 1-cycle pulse, strobe released (low -> high)
// Edges are taken between the last two flops so the first STAGES-1 flops
// act purely as metastability filters.
module snes_strobe_sync
  import snes_mem_arbiter_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe_n,
  output logic fell,
  output logic rose
);

  // sr[0] is the newest sample; resets to all-ones (bus idle)
  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '1;
    end else begin
      sr <= {sr[STAGES-2:0], strobe_n};
    end
  end

  assign fell =  sr[STAGES-1] & ~sr[STAGES-2];
  assign rose = ~sr[STAGES-1] &  sr[STAGES-2];

endmodule

// File: rtl/snes_mem_arbiter.sv
// snes_mem_arbiter: converts decoded SNES bus cycles into single-byte
// requests on the shared ROM/SaveRAM controller and arbitrates them against
// GSU core requests (SNES has priority, GSU accesses are never pre-empted).
//   CLK, RST                     : system clock, synchronous active-high reset
//   SNES_RD, SNES_WR             : raw asynchronous active-low SNES strobes
//   ROM_ADDR/ROM_HIT/IS_WRITABLE : decoder outputs for the current SNES cycle
//   SNES_DATA_IN / SNES_DATA_OUT : SNES write data / latched SNES read data
//   gsu_*                        : GSU level request, ack pulse and data
//   mem_*                        : held request to the memory controller
//   snes_busy                    : SNES access pending or in flight
module snes_mem_arbiter
  import snes_mem_arbiter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int unsigned ADDR_W      = 24
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SNES_RD,
  input  logic              SNES_WR,
  input  logic [ADDR_W-1:0] ROM_ADDR,
  input  logic              ROM_HIT,
  input  logic              IS_WRITABLE,
  input  logic [7:0]        SNES_DATA_IN,
  output logic [7:0]        SNES_DATA_OUT,
  input  logic              gsu_req,
  input  logic              gsu_we,
  input  logic [ADDR_W-1:0] gsu_addr,
  input  logic [7:0]        gsu_wrdata,
  output logic [7:0]        gsu_rddata,
  output logic              gsu_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wrdata,
  input  logic [7:0]        mem_rddata,
  input  logic              mem_ack,
  output logic              snes_busy
);

  logic rd_fell, rd_rose_unused, wr_fell, wr_rose;

  snes_strobe_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clk      (CLK),
    .rst      (RST),
    .strobe_n (SNES_RD),
    .fell     (rd_fell),
    .rose     (rd_rose_unused)
  );

  snes_strobe_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clk      (CLK),
    .rst      (RST),
    .strobe_n (SNES_WR),
    .fell     (wr_fell),
    .rose     (wr_rose)
  );

  arb_state_t        state;
  logic              snes_pend, snes_pend_we;
  logic [ADDR_W-1:0] snes_pend_addr;
  logic [7:0]        snes_pend_data;
  logic              wr_armed;
  logic [ADDR_W-1:0] wr_arm_addr;

  // SNES access completed by the bus this cycle
  logic              ev_valid, ev_we;
  logic [ADDR_W-1:0] ev_addr;
  logic [7:0]        ev_data;

  always_comb begin
    ev_valid = 1'b0;
    ev_we    = 1'b0;
    ev_addr  = ROM_ADDR;
    ev_data  = SNES_DATA_IN;
    if (wr_rose && wr_armed) begin
      ev_valid = 1'b1;
      ev_we    = 1'b1;
      ev_addr  = wr_arm_addr;
    end else if (rd_fell && ROM_HIT) begin
      ev_valid = 1'b1;
    end
  end

  // An edge arriving in IDLE with nothing pending is issued straight to
  // memory instead of going through the pending latch; this keeps the
  // edge -> mem_req latency at one cycle and lets it beat a GSU request
  // raised in the same cycle.
  logic              ev_direct;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_data;

  assign ev_direct = (state == ST_IDLE) && !snes_pend && ev_valid;
  assign sel_we    = snes_pend ? snes_pend_we   : ev_we;
  assign sel_addr  = snes_pend ? snes_pend_addr : ev_addr;
  assign sel_data  = snes_pend ? snes_pend_data : ev_data;

  assign snes_busy = snes_pend | (state == ST_SNES);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= ST_IDLE;
      SNES_DATA_OUT  <= '0;
      gsu_rddata     <= '0;
      gsu_ack        <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wrdata     <= '0;
      snes_pend      <= 1'b0;
      snes_pend_we   <= 1'b0;
      snes_pend_addr <= '0;
      snes_pend_data <= '0;
      wr_armed       <= 1'b0;
      wr_arm_addr    <= '0;
    end else begin
      gsu_ack <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (snes_pend || ev_valid) begin
            state      <= ST_SNES;
            mem_req    <= 1'b1;
            mem_we     <= sel_we;
            mem_addr   <= sel_addr;
            mem_wrdata <= sel_data;
          // gsu_req is still high in the cycle gsu_ack is visible; do not
          // start a second access for the request just completed.
          end else if (gsu_req && !gsu_ack) begin
            state      <= ST_GSU;
            mem_req    <= 1'b1;
            mem_we     <= gsu_we;
            mem_addr   <= gsu_addr;
            mem_wrdata <= gsu_wrdata;
          end
        end
        ST_SNES: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) SNES_DATA_OUT <= mem_rddata;
            state   <= ST_IDLE;
          end
        end
        ST_GSU: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) gsu_rddata <= mem_rddata;
            gsu_ack <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Pending latch: served entry clears, a newer edge overwrites it
      if (state == ST_IDLE && snes_pend) snes_pend <= 1'b0;
      if (ev_valid && !ev_direct) begin
        snes_pend      <= 1'b1;
        snes_pend_we   <= ev_we;
        snes_pend_addr <= ev_addr;
        snes_pend_data <= ev_data;
      end

      if (wr_fell && ROM_HIT && IS_WRITABLE) begin
        wr_armed    <= 1'b1;
        wr_arm_addr <= ROM_ADDR;
      end else if (wr_rose) begin
        wr_armed    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snes_mem_arbiter.sv
module tb_snes_mem_arbiter;

  localparam int unsigned SYNC = 3;

  logic        CLK, RST, SNES_RD, SNES_WR, ROM_HIT, IS_WRITABLE;
  logic [23:0] ROM_ADDR, gsu_addr, mem_addr;
  logic [7:0]  SNES_DATA_IN, SNES_DATA_OUT, gsu_wrdata, gsu_rddata, mem_wrdata, mem_rddata;
  logic        gsu_req, gsu_we, gsu_ack, mem_req, mem_we, mem_ack, snes_busy;

  snes_mem_arbiter #(.SYNC_STAGES(SYNC), .ADDR_W(24)) dut (
    .CLK(CLK), .RST(RST), .SNES_RD(SNES_RD), .SNES_WR(SNES_WR),
    .ROM_ADDR(ROM_ADDR), .ROM_HIT(ROM_HIT), .IS_WRITABLE(IS_WRITABLE),
    .SNES_DATA_IN(SNES_DATA_IN), .SNES_DATA_OUT(SNES_DATA_OUT),
    .gsu_req(gsu_req), .gsu_we(gsu_we), .gsu_addr(gsu_addr), .gsu_wrdata(gsu_wrdata),
    .gsu_rddata(gsu_rddata), .gsu_ack(gsu_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wrdata(mem_wrdata),
    .mem_rddata(mem_rddata), .mem_ack(mem_ack), .snes_busy(snes_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [7:0]  data;
    int unsigned cyc;
  } req_t;

  req_t        log[$];
  req_t        cur;
  logic [7:0]  mem_model [logic [23:0]];
  int unsigned n_checks = 0, n_errors = 0;
  int unsigned cyc = 0, gsu_ack_cnt = 0, stable_err = 0, wait_left = 0;
  int unsigned ack_delay = 4;
  logic        in_flight = 1'b0, resp_en = 1'b1, inject_ack = 1'b0;
  logic [7:0]  exp_snes_out = 8'h00, exp_gsu_rd = 8'h00;

  function automatic logic [7:0] model_rd(input logic [23:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // Memory controller model: logs each request, checks it is held stable,
  // acks after ack_delay cycles, and applies writes to the memory array.
  initial begin
    mem_ack = 1'b0;
    mem_rddata = 8'h00;
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      if (gsu_ack === 1'b1) gsu_ack_cnt++;
      if (!resp_en) begin
        mem_ack = inject_ack;
        mem_rddata = 8'hEE;
        in_flight = 1'b0;
      end else begin
        mem_ack = 1'b0;
        if (RST) begin
          in_flight = 1'b0;
        end else if (in_flight) begin
          if (mem_req !== 1'b1 || mem_we !== cur.we || mem_addr !== cur.addr ||
              (cur.we && mem_wrdata !== cur.data))
            stable_err++;
          if (wait_left == 0) begin
            mem_ack = 1'b1;
            if (cur.we) begin
              mem_model[cur.addr] = cur.data;
              mem_rddata = 8'($urandom);
            end else begin
              mem_rddata = model_rd(cur.addr);
            end
            in_flight = 1'b0;
          end else begin
            wait_left--;
          end
        end else if (mem_req === 1'b1) begin
          cur.we = mem_we; cur.addr = mem_addr; cur.data = mem_wrdata; cur.cyc = cyc;
          log.push_back(cur);
          in_flight = 1'b1;
          wait_left = ack_delay - 1;
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int unsigned k = 0;
    while ((mem_req || snes_busy || in_flight) && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check("idle_timeout", 32'(k < 200), 1);
  endtask

  task automatic snes_read(input logic [23:0] a, input logic hit);
    int unsigned n0 = log.size();
    logic [7:0] exp_d = hit ? model_rd(a) : exp_snes_out;
    ROM_ADDR = a; ROM_HIT = hit; IS_WRITABLE = 1'b0; SNES_RD = 1'b0;
    repeat (6) @(negedge CLK);
    SNES_RD = 1'b1;
    repeat (4) @(negedge CLK);
    wait_idle();
    ROM_HIT = 1'b0;
    check("rd_nreq", log.size() - n0, hit ? 1 : 0);
    if (hit && log.size() > n0) begin
      check("rd_we", log[n0].we, 0);
      check("rd_addr", log[n0].addr, a);
    end
    check("rd_data", SNES_DATA_OUT, exp_d);
    exp_snes_out = exp_d;
  endtask

  task automatic snes_write(input logic [23:0] a, input logic hit, input logic wr, input logic [7:0] d);
    int unsigned n0 = log.size();
    int unsigned rise_cyc;
    logic exp_req = hit && wr;
    ROM_ADDR = a; ROM_HIT = hit; IS_WRITABLE = wr; SNES_DATA_IN = ~d; SNES_WR = 1'b0;
    repeat (5) @(negedge CLK);
    check("wr_early", log.size() - n0, 0);
    SNES_DATA_IN = d;
    repeat (2) @(negedge CLK);
    SNES_WR = 1'b1;
    rise_cyc = cyc;
    repeat (5) @(negedge CLK);
    SNES_DATA_IN = ~d;
    wait_idle();
    ROM_HIT = 1'b0; IS_WRITABLE = 1'b0;
    check("wr_nreq", log.size() - n0, exp_req ? 1 : 0);
    if (exp_req && log.size() > n0) begin
      check("wr_we", log[n0].we, 1);
      check("wr_addr", log[n0].addr, a);
      check("wr_data", log[n0].data, d);
      check("wr_after_rise", 32'(log[n0].cyc > rise_cyc), 1);
    end
    check("wr_snes_out", SNES_DATA_OUT, exp_snes_out);
  endtask

  task automatic gsu_op(input logic we, input logic [23:0] a, input logic [7:0] d);
    int unsigned n0 = log.size();
    int unsigned a0 = gsu_ack_cnt;
    int unsigned k = 0;
    logic [7:0] exp_d = we ? exp_gsu_rd : model_rd(a);
    gsu_req = 1'b1; gsu_we = we; gsu_addr = a; gsu_wrdata = d;
    while (!gsu_ack && k < 200) begin
      @(negedge CLK);
      k++;
    end
    gsu_req = 1'b0;
    check("gsu_timeout", 32'(k < 200), 1);
    check("gsu_rddata", gsu_rddata, exp_d);
    repeat (3) @(negedge CLK);
    check("gsu_ack_cnt", gsu_ack_cnt - a0, 1);
    check("gsu_nreq", log.size() - n0, 1);
    if (log.size() > n0) begin
      check("gsu_we", log[n0].we, we);
      check("gsu_addr", log[n0].addr, a);
      if (we) check("gsu_wdata", log[n0].data, d);
    end
    exp_gsu_rd = exp_d;
  endtask

  initial begin
    int unsigned n0, a0, k;
    logic [7:0] exp_s, exp_g;

    RST = 1'b1; SNES_RD = 1'b1; SNES_WR = 1'b1; ROM_ADDR = '0; ROM_HIT = 1'b0;
    IS_WRITABLE = 1'b0; SNES_DATA_IN = '0; gsu_req = 1'b0; gsu_we = 1'b0;
    gsu_addr = '0; gsu_wrdata = '0;
    repeat (3) @(negedge CLK);

    // Reset values
    check("rst_snes_out", SNES_DATA_OUT, 8'h00);
    check("rst_gsu_rd", gsu_rddata, 8'h00);
    check("rst_gsu_ack", gsu_ack, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wrdata, 0);
    check("rst_busy", snes_busy, 0);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    check("idle_no_req", mem_req, 0);

    // SNES ROM read
    mem_model[24'h012345] = 8'hA5;
    ack_delay = 4;
    snes_read(24'h012345, 1'b1);

    // SaveRAM write, then read back through the SNES
    snes_write(24'hE00010, 1'b1, 1'b1, 8'h3C);
    snes_read(24'hE00010, 1'b1);

    // Write to non-writable ROM area and a non-hit read: no memory cycle
    snes_write(24'h008000, 1'b1, 1'b0, 8'h11);
    snes_read(24'h002100, 1'b0);

    // GSU request and SNES read edge in the same cycle
    ack_delay = 3;
    n0 = log.size(); a0 = gsu_ack_cnt;
    exp_s = model_rd(24'h0400AA); exp_g = model_rd(24'hE00005);
    ROM_ADDR = 24'h0400AA; ROM_HIT = 1'b1; SNES_RD = 1'b0;
    gsu_we = 1'b0; gsu_addr = 24'hE00005;
    repeat (SYNC - 1) @(negedge CLK);
    gsu_req = 1'b1;
    @(negedge CLK);
    check("col_req", mem_req, 1);
    check("col_addr", mem_addr, 24'h0400AA);
    check("col_we", mem_we, 0);
    check("col_busy", snes_busy, 1);
    k = 0;
    while (!gsu_ack && k < 200) begin
      @(negedge CLK);
      k++;
    end
    gsu_req = 1'b0; SNES_RD = 1'b1;
    check("col_timeout", 32'(k < 200), 1);
    check("col_gsu_rd", gsu_rddata, exp_g);
    repeat (3) @(negedge CLK);
    wait_idle();
    ROM_HIT = 1'b0;
    check("col_nreq", log.size() - n0, 2);
    if (log.size() >= n0 + 2) begin
      check("col_first", log[n0].addr, 24'h0400AA);
      check("col_second", log[n0 + 1].addr, 24'hE00005);
    end
    check("col_snes_out", SNES_DATA_OUT, exp_s);
    check("col_ack_cnt", gsu_ack_cnt - a0, 1);
    exp_snes_out = exp_s; exp_gsu_rd = exp_g;

    // SNES read arriving while a GSU write is in flight
    ack_delay = 8;
    n0 = log.size(); a0 = gsu_ack_cnt;
    exp_s = model_rd(24'h00ABCD);
    gsu_req = 1'b1; gsu_we = 1'b1; gsu_addr = 24'hE00007; gsu_wrdata = 8'h77;
    k = 0;
    while (!mem_req && k < 50) begin
      @(negedge CLK);
      k++;
    end
    check("dur_gsu_start", mem_req, 1);
    ROM_ADDR = 24'h00ABCD; ROM_HIT = 1'b1; SNES_RD = 1'b0;
    repeat (4) @(negedge CLK);
    check("dur_busy", snes_busy, 1);
    check("dur_not_preempt", mem_addr, 24'hE00007);
    k = 0;
    while (!gsu_ack && k < 200) begin
      @(negedge CLK);
      k++;
    end
    gsu_req = 1'b0;
    check("dur_timeout", 32'(k < 200), 1);
    check("dur_req_drop", mem_req, 0);
    @(negedge CLK);
    check("dur_snes_req", mem_req, 1);
    check("dur_snes_addr", mem_addr, 24'h00ABCD);
    check("dur_snes_we", mem_we, 0);
    SNES_RD = 1'b1;
    wait_idle();
    ROM_HIT = 1'b0;
    check("dur_snes_out", SNES_DATA_OUT, exp_s);
    check("dur_nreq", log.size() - n0, 2);
    check("dur_ack_cnt", gsu_ack_cnt - a0, 1);
    exp_snes_out = exp_s;

    // Reset while a GSU access is outstanding and a SNES read is pending
    resp_en = 1'b0; inject_ack = 1'b0;
    a0 = gsu_ack_cnt;
    gsu_req = 1'b1; gsu_we = 1'b0; gsu_addr = 24'hE00003;
    k = 0;
    while (!mem_req && k < 50) begin
      @(negedge CLK);
      k++;
    end
    check("rst2_gsu_start", mem_req, 1);
    ROM_ADDR = 24'h001234; ROM_HIT = 1'b1; SNES_RD = 1'b0;
    repeat (4) @(negedge CLK);
    check("rst2_pend", snes_busy, 1);
    RST = 1'b1; SNES_RD = 1'b1; ROM_HIT = 1'b0; gsu_req = 1'b0;
    @(negedge CLK);
    check("rst2_mem_req", mem_req, 0);
    check("rst2_mem_we", mem_we, 0);
    check("rst2_mem_addr", mem_addr, 0);
    check("rst2_mem_wdata", mem_wrdata, 0);
    check("rst2_busy", snes_busy, 0);
    check("rst2_snes_out", SNES_DATA_OUT, 8'h00);
    check("rst2_gsu_rd", gsu_rddata, 8'h00);
    RST = 1'b0;
    @(negedge CLK);
    inject_ack = 1'b1;
    @(negedge CLK);
    inject_ack = 1'b0;
    repeat (4) @(negedge CLK);
    check("late_ack_req", mem_req, 0);
    check("late_ack_busy", snes_busy, 0);
    check("late_ack_gsu", gsu_ack_cnt - a0, 0);
    check("late_ack_gsu_rd", gsu_rddata, 8'h00);
    check("late_ack_snes", SNES_DATA_OUT, 8'h00);
    exp_snes_out = 8'h00; exp_gsu_rd = 8'h00;
    resp_en = 1'b1;
    repeat (2) @(negedge CLK);

    // Randomized mix of SNES and GSU accesses against the memory model
    for (int i = 0; i < 40; i++) begin
      logic [23:0] a;
      ack_delay = $urandom_range(1, 5);
      a = 24'hE00000 | 24'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: snes_read(a, 1'($urandom_range(0, 3) != 0));
        1: snes_write(a, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
        2: gsu_op(1'b0, a, 8'h00);
        default: gsu_op(1'b1, a, 8'($urandom));
      endcase
    end

    check("mem_stable", stable_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
